// File: rtl/traceback_reader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : traceback_reader_pkg                                            |
// | Desc     : Shared geometry, direction-code and op-code constants.          |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package traceback_reader_pkg;

    localparam int N      = 16;
    localparam int DIR_W  = 5;
    localparam int ADDR_W = 10;
    localparam int BLK_W  = 6;
    localparam int LOG2N  = $clog2(N);
    localparam int WORD_W = N * DIR_W;

    localparam logic [2:0] c_SRC_STOP = 3'd0;
    localparam logic [2:0] c_SRC_DIAG = 3'd1;
    localparam logic [2:0] c_SRC_E    = 3'd2;
    localparam logic [2:0] c_SRC_F    = 3'd3;
    localparam int         c_EXT_E    = 3;
    localparam int         c_EXT_F    = 4;

    localparam logic [1:0] c_OP_M = 2'd0;
    localparam logic [1:0] c_OP_I = 2'd1;
    localparam logic [1:0] c_OP_D = 2'd2;

    typedef enum logic [1:0] {
        MAT_H = 2'd0,
        MAT_E = 2'd1,
        MAT_F = 2'd2
    } mat_t;

    // Coordinates are 1-based; ADDR_W - LOG2N == BLK_W so the block cast is lossless.
    function automatic logic [BLK_W-1:0] blk_of(input logic [ADDR_W-1:0] x);
        logic [ADDR_W-1:0] xm1;
        xm1 = x - ADDR_W'(1);
        return BLK_W'(xm1 >> LOG2N);
    endfunction

    function automatic logic [LOG2N-1:0] pe_of(input logic [ADDR_W-1:0] x);
        logic [ADDR_W-1:0] xm1;
        xm1 = x - ADDR_W'(1);
        return xm1[LOG2N-1:0];
    endfunction

    function automatic logic [ADDR_W-1:0] col_of(input logic [ADDR_W-1:0] y);
        return y - ADDR_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/traceback_reader_dir_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : traceback_reader_dir_decode                                     |
// | Desc     : Picks one PE code out of a direction word and decodes the step. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module traceback_reader_dir_decode
    import traceback_reader_pkg::*;
(
    input  logic [WORD_W-1:0] i_word,
    input  logic [LOG2N-1:0]  i_p,
    input  mat_t              i_mat,
    output logic [1:0]        o_op,
    output mat_t              o_next_mat,
    output logic              o_dx,
    output logic              o_dy,
    output logic              o_emit,
    output logic              o_stop,
    output logic              o_illegal
);

    logic [DIR_W-1:0] w_code;

    // PE 0 sits in the most significant slot of the word.
    assign w_code = i_word[(N - 1 - int'(i_p)) * DIR_W +: DIR_W];

    always_comb begin
        o_op       = c_OP_M;
        o_next_mat = i_mat;
        o_dx       = 1'b0;
        o_dy       = 1'b0;
        o_emit     = 1'b0;
        o_stop     = 1'b0;
        o_illegal  = 1'b0;
        case (i_mat)
            MAT_H: begin
                case (w_code[2:0])
                    c_SRC_STOP: o_stop = 1'b1;
                    c_SRC_DIAG: begin
                        o_emit = 1'b1;
                        o_dx   = 1'b1;
                        o_dy   = 1'b1;
                    end
                    c_SRC_E:    o_next_mat = MAT_E;
                    c_SRC_F:    o_next_mat = MAT_F;
                    default:    o_illegal  = 1'b1;
                endcase
            end
            MAT_E: begin
                o_emit     = 1'b1;
                o_op       = c_OP_I;
                o_dy       = 1'b1;
                o_next_mat = w_code[c_EXT_E] ? MAT_E : MAT_H;
            end
            MAT_F: begin
                o_emit     = 1'b1;
                o_op       = c_OP_D;
                o_dx       = 1'b1;
                o_next_mat = w_code[c_EXT_F] ? MAT_F : MAT_H;
            end
            default: begin
                o_next_mat = MAT_H;
                o_stop     = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/traceback_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : traceback_reader                                                |
// | Desc     : Walks stored direction codes back from the best cell, one op    |
// |            per step on a valid/ready stream, then reports the start cell.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module traceback_reader
    import traceback_reader_pkg::*;
(
    input  logic              clk,
    input  logic              reset_i,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_x,
    input  logic [ADDR_W-1:0] start_y,
    output logic [BLK_W-1:0]  mem_block_num,
    output logic [ADDR_W-1:0] column_num,
    input  logic [WORD_W-1:0] column_k0,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [1:0]        op,
    output logic [ADDR_W-1:0] op_x,
    output logic [ADDR_W-1:0] op_y,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] end_x,
    output logic [ADDR_W-1:0] end_y,
    output logic              err
);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_FETCH  = 3'd1;
    localparam logic [2:0] c_ST_WAIT   = 3'd2;
    localparam logic [2:0] c_ST_DECODE = 3'd3;
    localparam logic [2:0] c_ST_EMIT   = 3'd4;
    localparam logic [2:0] c_ST_DONE   = 3'd5;

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_x, r_y;
    mat_t              r_mat;
    logic [WORD_W-1:0] r_word;
    logic [BLK_W-1:0]  r_blk;
    logic [ADDR_W-1:0] r_col;
    logic              r_dx, r_dy;
    logic [BLK_W-1:0]  r_mem_block_num;
    logic [ADDR_W-1:0] r_column_num;
    logic              r_op_valid;
    logic [1:0]        r_op;
    logic [ADDR_W-1:0] r_op_x, r_op_y;
    logic              r_busy, r_done, r_err;
    logic [ADDR_W-1:0] r_end_x, r_end_y;

    logic [1:0]        w_op;
    mat_t              w_next_mat;
    logic              w_dx, w_dy, w_emit, w_stop, w_illegal;
    logic [ADDR_W-1:0] w_nx, w_ny;

    traceback_reader_dir_decode u_dir_decode (
        .i_word     (r_word),
        .i_p        (pe_of(r_x)),
        .i_mat      (r_mat),
        .o_op       (w_op),
        .o_next_mat (w_next_mat),
        .o_dx       (w_dx),
        .o_dy       (w_dy),
        .o_emit     (w_emit),
        .o_stop     (w_stop),
        .o_illegal  (w_illegal)
    );

    assign w_nx = r_x - ADDR_W'(r_dx);
    assign w_ny = r_y - ADDR_W'(r_dy);

    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_state         <= c_ST_IDLE;
            r_x             <= '0;
            r_y             <= '0;
            r_mat           <= MAT_H;
            r_word          <= '0;
            r_blk           <= '0;
            r_col           <= '0;
            r_dx            <= 1'b0;
            r_dy            <= 1'b0;
            r_mem_block_num <= '0;
            r_column_num    <= '0;
            r_op_valid      <= 1'b0;
            r_op            <= '0;
            r_op_x          <= '0;
            r_op_y          <= '0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_err           <= 1'b0;
            r_end_x         <= '0;
            r_end_y         <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_x     <= start_x;
                        r_y     <= start_y;
                        r_mat   <= MAT_H;
                        r_err   <= 1'b0;
                        r_end_x <= '0;
                        r_end_y <= '0;
                        r_busy  <= 1'b1;
                        if (start_x == '0 || start_y == '0) begin
                            r_state <= c_ST_DONE;
                        end else begin
                            r_mem_block_num <= blk_of(start_x);
                            r_column_num    <= col_of(start_y);
                            r_state         <= c_ST_FETCH;
                        end
                    end
                end
                // Address is already on the port; the SRAM captures it this cycle.
                c_ST_FETCH: r_state <= c_ST_WAIT;
                c_ST_WAIT: begin
                    r_word  <= column_k0;
                    r_blk   <= r_mem_block_num;
                    r_col   <= r_column_num;
                    r_state <= c_ST_DECODE;
                end
                c_ST_DECODE: begin
                    r_mat <= w_next_mat;
                    if (w_illegal) begin
                        r_err   <= 1'b1;
                        r_state <= c_ST_DONE;
                    end else if (w_stop) begin
                        r_state <= c_ST_DONE;
                    end else if (w_emit) begin
                        r_op       <= w_op;
                        r_op_x     <= r_x;
                        r_op_y     <= r_y;
                        r_op_valid <= 1'b1;
                        r_dx       <= w_dx;
                        r_dy       <= w_dy;
                        r_state    <= c_ST_EMIT;
                    end
                end
                c_ST_EMIT: begin
                    if (op_ready) begin
                        r_op_valid <= 1'b0;
                        r_x        <= w_nx;
                        r_y        <= w_ny;
                        if (w_nx == '0 || w_ny == '0) begin
                            r_state <= c_ST_DONE;
                        end else if (blk_of(w_nx) == r_blk && col_of(w_ny) == r_col) begin
                            r_state <= c_ST_DECODE;
                        end else begin
                            r_mem_block_num <= blk_of(w_nx);
                            r_column_num    <= col_of(w_ny);
                            r_state         <= c_ST_FETCH;
                        end
                    end
                end
                c_ST_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_end_x <= r_x;
                    r_end_y <= r_y;
                    r_state <= c_ST_IDLE;
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign mem_block_num = r_mem_block_num;
    assign column_num    = r_column_num;
    assign op_valid      = r_op_valid;
    assign op            = r_op;
    assign op_x          = r_op_x;
    assign op_y          = r_op_y;
    assign busy          = r_busy;
    assign done          = r_done;
    assign end_x         = r_end_x;
    assign end_y         = r_end_y;
    assign err           = r_err;

endmodule
`default_nettype wire
